// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared widths, axis region flags and VESA mode presets for the raster generator
package vga_timing_gen_pkg;
  localparam int COORD_W_DEF = 11;
  localparam int COL_W_DEF = 7;
  localparam int ROW_W_DEF = 6;
  localparam int CX_W_DEF = 3;
  localparam int CY_W_DEF = 4;
  typedef struct packed {
    logic active;
    logic sync;
  } region_t;
  typedef struct packed {
    int   h_visible, h_front, h_sync, h_back;
    int   v_visible, v_front, v_sync, v_back;
    logic h_pol, v_pol;
  } mode_t;
  localparam mode_t MODE_800X600_72 = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};
  localparam mode_t MODE_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam mode_t MODE_1024X768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; position, wrap and active/sync flags registered from next position
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int VISIBLE = 800,
  parameter int FRONT = 56,
  parameter int SYNC = 120,
  parameter int BACK = 64,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] pos,
  output logic [W-1:0] nxt,
  output logic         wrap,
  output region_t      flags
);
  localparam int TOTAL = BACK + VISIBLE + FRONT + SYNC;
  localparam logic [W-1:0] A0 = W'(BACK);
  localparam logic [W-1:0] A1 = W'(BACK + VISIBLE);
  localparam logic [W-1:0] S0 = W'(BACK + VISIBLE + FRONT);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  assign wrap = pos == LAST;
  assign nxt = wrap ? '0 : pos + W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pos <= '0;
      flags <= '0;
    end else if (en) begin
      pos <= nxt;
      flags.active <= nxt >= A0 && nxt < A1;
      flags.sync <= nxt >= S0;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing with text-cell counters and fetch strobes; VGA_TIMING_BLINK_EN adds a frame-counted blink
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT = 56,
  parameter int H_SYNC = 120,
  parameter int H_BACK = 64,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT = 37,
  parameter int V_SYNC = 6,
  parameter int V_BACK = 23,
  parameter int H_SYNC_POL = 1,
  parameter int V_SYNC_POL = 1,
  parameter int PIX_DIV = 1,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 10,
  parameter int LOAD_LEAD = 7,
  parameter int COORD_W = COORD_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF,
  parameter int CX_W = CX_W_DEF,
  parameter int CY_W = CY_W_DEF,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic               drawing,
  output logic [CX_W-1:0]    xchar,
  output logic [CY_W-1:0]    ychar,
  output logic [COL_W-1:0]   xtext,
  output logic [ROW_W-1:0]   ytext,
  output logic               clk_load_char,
  output logic               clk_load_design,
  output logic               clk_draw_char,
  output logic               line_start,
  output logic               frame_start,
  output logic               blink
);
  localparam int H_TOTAL = H_BACK + H_VISIBLE + H_FRONT + H_SYNC;
  localparam int V_TOTAL = V_BACK + V_VISIBLE + V_FRONT + V_SYNC;
  localparam int DW = $clog2(PIX_DIV + 1);
  localparam logic [DW-1:0] DL = DW'(PIX_DIV - 1);
  localparam logic [COORD_W-1:0] XD0 = COORD_W'(H_BACK);
  localparam logic [COORD_W-1:0] LW0 = COORD_W'(H_BACK - LOAD_LEAD);
  localparam logic [COORD_W-1:0] LW1 = COORD_W'(H_BACK + H_VISIBLE - LOAD_LEAD);
  localparam logic [COORD_W-1:0] LD0 = COORD_W'(H_BACK - LOAD_LEAD + CHAR_W / 2);
  localparam logic [COORD_W-1:0] LD1 = COORD_W'(H_BACK + H_VISIBLE - LOAD_LEAD + CHAR_W / 2);
  localparam logic [COORD_W-1:0] YD0 = COORD_W'(V_BACK);
  localparam logic [CX_W-1:0] CXL = CX_W'(CHAR_W - 1);
  localparam logic [CX_W-1:0] CXH = CX_W'(CHAR_W / 2);
  localparam logic [CY_W-1:0] CYL = CY_W'(CHAR_H - 1);
  if (LOAD_LEAD > H_BACK || CHAR_W < 2 || PIX_DIV < 1 || BLINK_FRAMES < 1 ||
      H_TOTAL >= 2 ** COORD_W || V_TOTAL >= 2 ** COORD_W ||
      H_VISIBLE > CHAR_W * 2 ** COL_W || V_VISIBLE > CHAR_H * 2 ** ROW_W) begin : g_bad_cfg
    $error("vga_timing_gen: inconsistent timing/width parameters");
  end
  logic [DW-1:0] cnt, cnt_n;
  logic [COORD_W-1:0] hnxt, vnxt, vn;
  logic hwrap, vwrap, lw_h, ld_h, lw;
  region_t hr, vr;
  logic [CX_W-1:0] xc, ph;
  logic [COL_W-1:0] xt;
  logic [CY_W-1:0] yc;
  logic [ROW_W-1:0] yt;
  assign cnt_n = cnt == DL ? '0 : cnt + DW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      pix_en <= 1'b0;
    end else begin
      cnt <= cnt_n;
      pix_en <= cnt_n == DL;
    end
  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(COORD_W)
  ) u_h (
    .clk(clk), .reset(reset), .en(pix_en), .pos(xpos), .nxt(hnxt), .wrap(hwrap), .flags(hr)
  );
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(COORD_W)
  ) u_v (
    .clk(clk), .reset(reset), .en(pix_en & hwrap), .pos(ypos), .nxt(vnxt), .wrap(vwrap), .flags(vr)
  );
  assign vn = hwrap ? vnxt : ypos;
  assign drawing = hr.active & vr.active;
  assign lw = lw_h & vr.active;
  assign hsync = (H_SYNC_POL != 0) ? hr.sync : ~hr.sync;
  assign vsync = (V_SYNC_POL != 0) ? vr.sync : ~vr.sync;
  assign xchar = drawing ? xc : '0;
  assign ychar = drawing ? yc : '0;
  assign xtext = lw ? xt : '0;
  assign ytext = vr.active ? yt : '0;
  assign clk_load_char = lw & ph == '0;
  // glyph fetch trails the code fetch by half a cell, so its phase zero is ph == CHAR_W/2
  assign clk_load_design = ld_h & vr.active & ph == CXH;
  assign clk_draw_char = drawing & xc == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      xc <= '0;
      ph <= '0;
      xt <= '0;
      yc <= '0;
      yt <= '0;
      lw_h <= 1'b0;
      ld_h <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      xc <= hnxt == XD0 || xc == CXL ? '0 : xc + CX_W'(1);
      ph <= hnxt == LW0 || ph == CXL ? '0 : ph + CX_W'(1);
      xt <= hnxt == LW0 ? '0 : xt + COL_W'(ph == CXL);
      lw_h <= hnxt >= LW0 && hnxt < LW1;
      ld_h <= hnxt >= LD0 && hnxt < LD1;
      line_start <= hwrap;
      frame_start <= hwrap & vwrap;
      if (hwrap) begin
        yc <= vn == YD0 ? '0 : vr.active ? (yc == CYL ? '0 : yc + CY_W'(1)) : yc;
        yt <= vn == YD0 ? '0 : yt + ROW_W'(vr.active && yc == CYL);
      end
    end
`ifdef VGA_TIMING_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FL = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0] fc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fc <= '0;
      blink <= 1'b0;
    end else if (pix_en & hwrap & vwrap) begin
      fc <= fc == FL ? '0 : fc + FW'(1);
      blink <= blink ^ (fc == FL);
    end
`else
  assign blink = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a reduced 52x29 raster with PIX_DIV=2 and mixed sync polarity
module tb_vga_timing_gen;
  typedef struct packed {
    logic       hs, vs, dr;
    logic [2:0] xc;
    logic [3:0] yc;
    logic [6:0] xt;
    logic [5:0] yt;
    logic       lc, ld, dc, ls, fs, bl;
  } obs_t;
  typedef struct {
    int   f, x, y;
    obs_t o;
  } rec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic pix_en, hsync, vsync, drawing, clk_load_char, clk_load_design, clk_draw_char;
  logic line_start, frame_start, blink;
  logic [10:0] xpos, ypos;
  logic [2:0] xchar;
  logic [3:0] ychar;
  logic [6:0] xtext;
  logic [5:0] ytext;
  obs_t cur;
  rec_t q[$];
  rec_t me;
  int checks = 0, failures = 0;
  int cyc = 0, fr = 0, t1 = 0, flen = 0, dur = 0, pe = 0, bad_dur = 0, bad_reg = 0, mx, my;
  logic [10:0] px = 0, py = 0;
  logic first = 1'b1, vd, dr;
  always #5 clk = ~clk;
  vga_timing_gen #(
    .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(6), .H_BACK(10),
    .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
    .H_SYNC_POL(1), .V_SYNC_POL(0), .PIX_DIV(2), .CHAR_W(8), .CHAR_H(5),
    .LOAD_LEAD(7), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .xpos(xpos), .ypos(ypos), .drawing(drawing), .xchar(xchar), .ychar(ychar),
    .xtext(xtext), .ytext(ytext), .clk_load_char(clk_load_char),
    .clk_load_design(clk_load_design), .clk_draw_char(clk_draw_char),
    .line_start(line_start), .frame_start(frame_start), .blink(blink)
  );
  assign cur = {hsync, vsync, drawing, xchar, ychar, xtext, ytext, clk_load_char,
                clk_load_design, clk_draw_char, line_start, frame_start, blink};
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  function automatic logic bx(input int f);
`ifdef VGA_TIMING_BLINK_EN
    return ((f / 2) % 2) != 0;
`else
    return 1'b0;
`endif
  endfunction
  task automatic push(input int f, x, y, input logic hs, vs, d, input int xc, yc, xt, yt,
                      input logic lc, ld, dc, ls, fs, bl);
    rec_t r;
    r.f = f;
    r.x = x;
    r.y = y;
    r.o = {hs, vs, d, 3'(xc), 4'(yc), 7'(xt), 6'(yt), lc, ld, dc, ls, fs, bl};
    q.push_back(r);
  endtask
  task automatic drain(input string n, input int lim);
    int i = 0;
    while (q.size() > 0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk(n, q.size(), 0);
    q.delete();
  endtask
  // monitor: one scoreboard pop per new pixel, plus per-sample region and pixel-duration tallies
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      fr = 0;
      px = 0;
      py = 0;
      first = 1'b1;
      dur = 0;
      pe = 0;
    end else begin
      if (xpos != px || ypos != py) begin
        if (!first && (dur != 2 || pe != 1)) bad_dur++;
        first = 1'b0;
        px = xpos;
        py = ypos;
        dur = 0;
        pe = 0;
        if (xpos == 0 && ypos == 0) begin
          fr++;
          if (fr == 1) t1 = cyc;
          if (fr == 2) flen = cyc - t1;
        end
        if (q.size() > 0 && q[0].f == fr && q[0].x == int'(xpos) && q[0].y == int'(ypos)) begin
          me = q.pop_front();
          chk($sformatf("px_f%0d_x%0d_y%0d", me.f, me.x, me.y), 64'(cur), 64'(me.o));
        end
      end
      dur++;
      pe += int'(pix_en);
      mx = int'(xpos);
      my = int'(ypos);
      vd = my >= 4 && my < 24;
      dr = vd && mx >= 10 && mx < 42;
      if (hsync !== (mx >= 46) || vsync !== !(my >= 26) || drawing !== dr ||
          line_start !== (mx == 0 && (my != 0 || fr > 0)) ||
          frame_start !== (mx == 0 && my == 0 && fr > 0) ||
          clk_draw_char !== (dr && (mx - 10) % 8 == 0) ||
          clk_load_char !== (vd && mx >= 3 && mx < 35 && (mx - 3) % 8 == 0) ||
          clk_load_design !== (vd && mx >= 7 && mx < 39 && (mx - 7) % 8 == 0))
        bad_reg++;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
  initial begin
    obs_t ro;
    int i;
    ro = '0;
    ro.vs = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {xpos, ypos, pix_en, cur}, {22'd0, 1'b0, ro});
    push(0, 1, 0,   0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, bx(0));
    push(0, 3, 4,   0, 1, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, bx(0));
    push(0, 7, 4,   0, 1, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, bx(0));
    push(0, 10, 4,  0, 1, 1,  0, 0, 0, 0,  0, 0, 1, 0, 0, bx(0));
    push(0, 11, 4,  0, 1, 1,  1, 0, 1, 0,  1, 0, 0, 0, 0, bx(0));
    push(0, 31, 4,  0, 1, 1,  5, 0, 3, 0,  0, 1, 0, 0, 0, bx(0));
    push(0, 45, 5,  0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, bx(0));
    push(0, 46, 5,  1, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, bx(0));
    push(0, 0, 6,   0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 1, 0, bx(0));
    push(0, 34, 8,  0, 1, 1,  0, 4, 3, 0,  0, 0, 1, 0, 0, bx(0));
    push(0, 18, 9,  0, 1, 1,  0, 0, 1, 1,  0, 0, 1, 0, 0, bx(0));
    push(0, 34, 23, 0, 1, 1,  0, 4, 3, 3,  0, 0, 1, 0, 0, bx(0));
    push(0, 41, 23, 0, 1, 1,  7, 4, 0, 3,  0, 0, 0, 0, 0, bx(0));
    push(0, 31, 24, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, bx(0));
    push(0, 20, 26, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, bx(0));
    push(0, 51, 28, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, bx(0));
    push(1, 0, 0,   0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, bx(1));
    push(2, 0, 0,   0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, bx(2));
    push(3, 5, 3,   0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, bx(3));
    push(4, 0, 0,   0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, bx(4));
    #1 reset = 1'b0;
    drain("drain_frames", 20000);
    chk("frame_clks", flen, 3016);
    i = 0;
    while (!(xpos == 20 && ypos == 10) && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk("reach_mid_frame", {xpos, ypos}, {11'd20, 11'd10});
    #2 reset = 1'b1;
    #1 chk("async_reset", {xpos, ypos, pix_en, cur}, {22'd0, 1'b0, ro});
    push(0, 1, 0,   0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1'b0);
    push(1, 0, 0,   0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("first_advance", xpos, 11'd1);
    drain("drain_after_reset", 4000);
    chk("pixel_timing", bad_dur, 0);
    chk("region_decode", bad_reg, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
